// File: rtl/ccff_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ccff_pkg
// Brief    : Shared types and helpers for configuration-chain memories.
// Revision : 1.0 - initial release
// ============================================================================
package ccff_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } ccff_state_t;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ccff_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : ccff_shift_reg
// Brief    : Serial config shift register with optional rotate (readback).
// Revision : 1.0 - initial release
// ============================================================================
module ccff_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             prog_clk,
    input  logic             prog_rst_n,
    input  logic             i_shift_en,
    input  logic             i_rotate,
    input  logic             i_din,
    output logic [WIDTH-1:0] o_q,
    output logic             o_tail
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;
    logic             w_in;

    assign w_in = i_rotate ? r_q[WIDTH-1] : i_din;

    generate
        if (WIDTH == 1) begin : g_single
            assign w_next = w_in;
        end else begin : g_multi
            assign w_next = {r_q[WIDTH-2:0], w_in};
        end
    endgenerate

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_q <= '0;
        end else if (i_shift_en) begin
            r_q <= w_next;
        end
    end

    assign o_q    = r_q;
    assign o_tail = r_q[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/ccff_mem_shadow.sv
`default_nettype none
// ============================================================================
// Module   : ccff_mem_shadow
// Brief    : Config-chain memory segment with committed shadow, fill
//            tracking, commit checking, circular readback and parity.
// Revision : 1.0 - initial release
// ============================================================================
module ccff_mem_shadow
    import ccff_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               SHADOW_EN = 1
) (
    input  logic             prog_clk,
    input  logic             prog_rst_n,
    input  logic             ccff_head,
    input  logic             ccff_shift_en,
    input  logic             ccff_readback,
    input  logic             ccff_commit,
    output logic             ccff_tail,
    output logic [WIDTH-1:0] mem_out,
    output logic [WIDTH-1:0] mem_outb,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic             cfg_parity
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] c_full = CW'(WIDTH);

    logic [WIDTH-1:0] w_sr_q;
    logic             w_data_shift;
    logic             w_commit_ok;
    logic             w_commit_rej;

    ccff_state_t      r_state;
    ccff_state_t      w_state_nxt;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             r_err;
    logic             r_parity;

    ccff_shift_reg #(
        .WIDTH (WIDTH)
    ) u_sr (
        .prog_clk   (prog_clk),
        .prog_rst_n (prog_rst_n),
        .i_shift_en (ccff_shift_en),
        .i_rotate   (ccff_readback),
        .i_din      (ccff_head),
        .o_q        (w_sr_q),
        .o_tail     (ccff_tail)
    );

    // Rotations never count as new data.
    assign w_data_shift = ccff_shift_en && !ccff_readback;
    assign w_commit_ok  = ccff_commit && !ccff_shift_en && (r_state == ST_FULL);
    assign w_commit_rej = ccff_commit && !w_commit_ok;

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_state <= ST_EMPTY;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (w_commit_ok) begin
            w_state_nxt = ST_EMPTY;
            w_count_nxt = '0;
        end else if (w_data_shift) begin
            if (r_count != c_full) begin
                w_count_nxt = r_count + CW'(1);
            end
            w_state_nxt = (w_count_nxt == c_full) ? ST_FULL : ST_PARTIAL;
        end
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_err    <= 1'b0;
            r_parity <= ^RESET_VAL;
        end else if (w_commit_ok) begin
            r_err    <= 1'b0;
            r_parity <= ^w_sr_q;
        end else if (w_commit_rej) begin
            r_err    <= 1'b1;
        end
    end

    generate
        if (SHADOW_EN != 0) begin : g_shadow
            logic [WIDTH-1:0] r_shadow;
            always_ff @(posedge prog_clk or negedge prog_rst_n) begin
                if (!prog_rst_n) begin
                    r_shadow <= RESET_VAL;
                end else if (w_commit_ok) begin
                    r_shadow <= w_sr_q;
                end
            end
            assign mem_out = r_shadow;
        end else begin : g_legacy
            assign mem_out = w_sr_q;
        end
    endgenerate

    assign mem_outb   = ~mem_out;
    assign cfg_done   = (r_state == ST_FULL);
    assign cfg_err    = r_err;
    assign cfg_parity = r_parity;

endmodule
`default_nettype wire

// File: tb/tb_ccff_mem_shadow.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccff_mem_shadow
// Brief    : Directed self-checking bench for ccff_mem_shadow (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccff_mem_shadow;

    localparam int         c_width = 4;
    localparam logic [3:0] c_rst   = 4'b1010;

    logic       prog_clk;
    logic       prog_rst_n;
    logic       ccff_head;
    logic       ccff_shift_en;
    logic       ccff_readback;
    logic       ccff_commit;
    logic       ccff_tail;
    logic [3:0] mem_out;
    logic [3:0] mem_outb;
    logic       cfg_done;
    logic       cfg_err;
    logic       cfg_parity;

    int r_total = 0;
    int r_bad   = 0;

    ccff_mem_shadow #(
        .WIDTH     (c_width),
        .RESET_VAL (c_rst),
        .SHADOW_EN (1)
    ) dut (
        .prog_clk      (prog_clk),
        .prog_rst_n    (prog_rst_n),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_readback (ccff_readback),
        .ccff_commit   (ccff_commit),
        .ccff_tail     (ccff_tail),
        .mem_out       (mem_out),
        .mem_outb      (mem_outb),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err),
        .cfg_parity    (cfg_parity)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_total++;
        if (got !== exp) begin
            r_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic idle();
        ccff_shift_en = 1'b0;
        ccff_readback = 1'b0;
        ccff_commit   = 1'b0;
        ccff_head     = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        prog_rst_n = 1'b0;
        tick();
        tick();
        prog_rst_n = 1'b1;
        tick();
    endtask

    task automatic shift_bit(input logic b);
        ccff_shift_en = 1'b1;
        ccff_readback = 1'b0;
        ccff_head     = b;
        tick();
        idle();
    endtask

    task automatic rotate();
        ccff_shift_en = 1'b1;
        ccff_readback = 1'b1;
        tick();
        idle();
    endtask

    task automatic commit();
        ccff_commit = 1'b1;
        tick();
        idle();
    endtask

    logic [3:0] v_bits;
    logic [3:0] v_tail;
    logic [5:0] v_six;
    logic [5:0] v_six_tail;

    initial begin
        idle();
        prog_rst_n = 1'b0;

        // Reset state
        do_reset();
        chk("rst_mem",    mem_out,    4'b1010);
        chk("rst_memb",   mem_outb,   4'b0101);
        chk("rst_par",    cfg_parity, 1'b0);
        chk("rst_done",   cfg_done,   1'b0);
        chk("rst_err",    cfg_err,    1'b0);
        chk("rst_tail",   ccff_tail,  1'b0);

        // Full load 1,1,0,1 then legal commit
        v_bits = 4'b1011;  // shifted bit i = v_bits[i]
        for (int i = 0; i < 4; i++) begin
            shift_bit(v_bits[i]);
            chk("ld_mem_hold", mem_out, 4'b1010);
        end
        chk("ld_done",  cfg_done,  1'b1);
        chk("ld_tail",  ccff_tail, 1'b1);
        commit();
        chk("cm_mem",   mem_out,    4'b1101);
        chk("cm_memb",  mem_outb,   4'b0010);
        chk("cm_par",   cfg_parity, 1'b1);
        chk("cm_done",  cfg_done,   1'b0);
        chk("cm_err",   cfg_err,    1'b0);

        // Partial commit rejected, then completed and accepted
        do_reset();
        shift_bit(1'b1);
        shift_bit(1'b0);
        commit();
        chk("pc_err",   cfg_err,  1'b1);
        chk("pc_mem",   mem_out,  4'b1010);
        chk("pc_done",  cfg_done, 1'b0);
        shift_bit(1'b1);
        shift_bit(1'b1);
        chk("pc_done2", cfg_done, 1'b1);
        commit();
        chk("pc_err2",  cfg_err,    1'b0);
        chk("pc_mem2",  mem_out,    4'b1011);
        chk("pc_par2",  cfg_parity, 1'b1);

        // Commit together with a shift is rejected, shift still happens
        do_reset();
        for (int i = 0; i < 4; i++) shift_bit(1'b1);
        ccff_shift_en = 1'b1;
        ccff_head     = 1'b0;
        ccff_commit   = 1'b1;
        tick();
        idle();
        chk("cs_err",   cfg_err,  1'b1);
        chk("cs_mem",   mem_out,  4'b1010);
        chk("cs_done",  cfg_done, 1'b1);

        // Readback rotation of 1101
        do_reset();
        for (int i = 0; i < 4; i++) shift_bit(v_bits[i]);
        commit();
        v_tail = 4'b1101;  // tail after rotation k = v_tail[k]
        for (int k = 0; k < 4; k++) begin
            rotate();
            chk("rb_tail", ccff_tail, v_tail[k]);
            chk("rb_mem",  mem_out,   4'b1101);
        end
        chk("rb_done", cfg_done, 1'b0);
        commit();
        chk("rb_err",  cfg_err,  1'b1);
        chk("rb_mem2", mem_out,  4'b1101);
        // Drain zeros to confirm contents restored to 1101
        v_tail = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            shift_bit(1'b0);
            chk("rb_drain", ccff_tail, v_tail[k]);
        end

        // Six shifts: pass-through on tail and saturating count
        do_reset();
        v_six      = 6'b001101;  // shifted 1,0,1,1,0,0
        v_six_tail = 6'b101000;  // tail after shift j
        for (int j = 0; j < 6; j++) begin
            shift_bit(v_six[j]);
            chk("s6_tail", ccff_tail, v_six_tail[j]);
        end
        chk("s6_done", cfg_done, 1'b1);
        commit();
        chk("s6_err",  cfg_err,  1'b0);
        chk("s6_mem",  mem_out,  4'b1100);
        chk("s6_par",  cfg_parity, 1'b0);
        chk("s6_done2", cfg_done, 1'b0);

        // Asynchronous reset mid-shift
        do_reset();
        for (int i = 0; i < 4; i++) shift_bit(v_bits[i]);
        commit();
        shift_bit(1'b1);
        shift_bit(1'b1);
        #2;
        prog_rst_n = 1'b0;
        #1;
        chk("ar_mem",  mem_out,    4'b1010);
        chk("ar_par",  cfg_parity, 1'b0);
        chk("ar_tail", ccff_tail,  1'b0);
        chk("ar_done", cfg_done,   1'b0);
        #1;
        prog_rst_n = 1'b1;
        tick();
        commit();
        chk("ar_err",  cfg_err,  1'b1);
        chk("ar_mem2", mem_out,  4'b1010);

        $display("test done: total=%0d bad=%0d", r_total, r_bad);
        $finish;
    end

endmodule
`default_nettype wire
